sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/sync_fifo_ctrl.sv | 132 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - FIFO controller over an external two-port RAM with a
// one-word output stage fed straight from the RAM's registered read data.
module sync_fifo_ctrl #(
    parameter int Width = 32,
    parameter int Depth = 256,
    localparam int Aw = $clog2(Depth),
    localparam int Lw = $clog2(Depth + 2)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,

    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_ready_o,

    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i,

    output logic             ram_we_o,
    output logic [Aw-1:0]    ram_waddr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic             ram_re_o,
    output logic [Aw-1:0]    ram_raddr_o,
    input  logic [Width-1:0] ram_rdata_i,

    output logic [Lw-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);
    localparam logic [Lw-1:0] CntFull  = Lw'(Depth);

    state_t          r_state;
    state_t          w_state_next;
    logic [Aw-1:0]   r_wptr;
    logic [Aw-1:0]   r_rptr;
    logic [Lw-1:0]   r_ram_cnt;

    logic            w_full;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic [Aw-1:0]   w_wptr_inc;
    logic [Aw-1:0]   w_rptr_inc;
    logic [Lw-1:0]   w_ram_cnt_next;

    assign w_full      = (r_ram_cnt == CntFull);
    assign w_out_valid = (r_state == ST_VALID);

    // Flush blocks new pushes and reads that cycle; a pop on the output still completes.
    assign in_ready_o  = !w_full && !flush_i;
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = w_out_valid && out_ready_i;
    assign w_issue     = (r_ram_cnt != '0) && (!w_out_valid || w_pop) && !flush_i;

    assign w_wptr_inc  = (r_wptr == LastAddr) ? '0 : r_wptr + 1'b1;
    assign w_rptr_inc  = (r_rptr == LastAddr) ? '0 : r_rptr + 1'b1;
    assign w_ram_cnt_next = r_ram_cnt + Lw'(w_push) - Lw'(w_issue);

    assign ram_we_o    = w_push;
    assign ram_waddr_o = r_wptr;
    assign ram_wdata_o = in_data_i;
    assign ram_re_o    = w_issue;
    assign ram_raddr_o = r_rptr;

    assign out_valid_o = w_out_valid;
    assign out_data_o  = ram_rdata_i;

    assign level_o     = r_ram_cnt + Lw'(w_out_valid);
    assign full_o      = w_full;
    assign empty_o     = (level_o == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_issue) begin
                    w_state_next = ST_VALID;
                end
            end
            ST_VALID: begin
                if (w_pop && !w_issue) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
        if (flush_i) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_ram_cnt <= '0;
        end else if (flush_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_ram_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_issue) begin
                r_rptr <= w_rptr_inc;
            end
            r_ram_cnt <= w_ram_cnt_next;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed bench for sync_fifo_ctrl with a RAM model
// and a data scoreboard (Width=8, Depth=4).
module tb_sync_fifo_ctrl;

    localparam int Width = 8;
    localparam int Depth = 4;
    localparam int Aw    = $clog2(Depth);
    localparam int Lw    = $clog2(Depth + 2);

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [Width-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [Width-1:0] out_data;
    logic             out_ready;
    logic             ram_we;
    logic [Aw-1:0]    ram_waddr;
    logic [Width-1:0] ram_wdata;
    logic             ram_re;
    logic [Aw-1:0]    ram_raddr;
    logic [Width-1:0] ram_rdata;
    logic [Lw-1:0]    level;
    logic             full;
    logic             empty;

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] q [$];
    int               checks;
    int               failures;
    int               exp_wptr;
    int               exp_rptr;
    int               n_pops;

    sync_fifo_ctrl #(.Width(Width), .Depth(Depth)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .ram_we_o    (ram_we),
        .ram_waddr_o (ram_waddr),
        .ram_wdata_o (ram_wdata),
        .ram_re_o    (ram_re),
        .ram_raddr_o (ram_raddr),
        .ram_rdata_i (ram_rdata),
        .level_o     (level),
        .full_o      (full),
        .empty_o     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-port RAM model: registered read, rdata held while re is low.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change only at negedge; this evaluates the cycle's handshakes, then
    // advances to the next negedge.
    task automatic tick();
        #2;
        chk("we_is_push", {31'd0, ram_we}, {31'd0, in_valid & in_ready});
        if (ram_we) begin
            chk("waddr", {30'd0, ram_waddr}, exp_wptr);
            chk("wdata", {24'd0, ram_wdata}, {24'd0, in_data});
            exp_wptr = (exp_wptr + 1) % Depth;
        end
        if (ram_re) begin
            chk("raddr", {30'd0, ram_raddr}, exp_rptr);
            exp_rptr = (exp_rptr + 1) % Depth;
        end
        if (in_valid && in_ready) q.push_back(in_data);
        if (out_valid && out_ready) begin
            n_pops++;
            chk("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) chk("sb_data", {24'd0, out_data}, {24'd0, q.pop_front()});
        end
        if (flush) begin
            q.delete();
            exp_wptr = 0;
            exp_rptr = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (level != 0); k++) tick();
        out_ready = 1'b0;
        chk("drain_level", {29'd0, level}, 32'd0);
        chk("drain_sb_empty", q.size(), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_wptr = 0;
        exp_rptr = 0;
        n_pops   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_re", {31'd0, ram_re}, 32'd0);
        @(negedge clk);

        // Single word latency
        in_valid = 1'b1;
        in_data  = 8'hA1;
        #1;
        chk("lat_we", {31'd0, ram_we}, 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("lat_re", {31'd0, ram_re}, 32'd1);
        chk("lat_raddr", {30'd0, ram_raddr}, 32'd0);
        chk("lat_c1_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_c2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_c2_data", {24'd0, out_data}, 32'hA1);
        chk("lat_c2_level", {29'd0, level}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("lat_empty_after_pop", {31'd0, empty}, 32'd1);

        // Fill to full with the consumer stalled
        n_pops = 0;
        for (int d = 1; d <= 5; d++) begin
            in_valid = 1'b1;
            in_data  = 8'(d);
            tick();
        end
        in_data = 8'h06;
        #1;
        chk("full_level", {29'd0, level}, 32'd5);
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_head", {24'd0, out_data}, 32'h01);
        tick();
        chk("full_refused_level", {29'd0, level}, 32'd5);

        // Pop frees a slot; in_ready rises the next cycle
        out_ready = 1'b1;
        #1;
        chk("pop_in_ready_same", {31'd0, in_ready}, 32'd0);
        tick();
        chk("pop_in_ready_next", {31'd0, in_ready}, 32'd1);
        tick();
        drain();
        chk("full_phase_pops", n_pops, 32'd6);

        // Streaming with both handshakes high
        n_pops    = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 8'h10 + 8'(i);
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_level_le2", {31'd0, level <= 2}, 32'd1);
            if (i >= 2) chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        chk("stream_pops_during", n_pops, 32'd10);
        drain();
        chk("stream_pops_total", n_pops, 32'd12);

        // Flush with three words held
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h31 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("pre_flush_level", {29'd0, level}, 32'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        chk("flush_we", {31'd0, ram_we}, 32'd0);
        chk("flush_re", {31'd0, ram_re}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_flush_level", {29'd0, level}, 32'd0);
        chk("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        chk("flush_first_word", {24'd0, out_data}, 32'h55);
        drain();

        // Asynchronous reset with three words held
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h41 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("pre_rst_level", {29'd0, level}, 32'd3);
        rst = 1'b1;
        #1;
        chk("async_rst_level", {29'd0, level}, 32'd0);
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_wptr = 0;
        exp_rptr = 0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_first_word", {24'd0, out_data}, 32'h55);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
